// File: rtl/rgb_pkg.sv
// Shared types and packing helpers for the RGB colour fader.
package rgb_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

  typedef enum logic {IDLE, FADING} fade_state_t;

  localparam int R_LSB = 17;
  localparam int G_LSB = 8;
  localparam int B_LSB = 0;

  // Bit 16 of the driver word is reserved and always left at zero.
  function automatic logic [24:0] pack_color(input rgb24_t c);
    logic [24:0] w;
    w = '0;
    w[R_LSB +: 8] = c.r;
    w[G_LSB +: 8] = c.g;
    w[B_LSB +: 8] = c.b;
    return w;
  endfunction

endpackage

// File: rtl/rgb_channel_stepper.sv
// One 8-bit colour channel: loads on snap, otherwise steps one LSB toward target per tick.
module rgb_channel_stepper (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  input  logic       i_tick,
  input  logic [7:0] i_tgt,
  output logic [7:0] o_val,
  output logic       o_at_target,
  output logic       o_near
);

  logic [7:0] r_val;
  logic [8:0] w_diff;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_val <= '0;
    end else if (i_load) begin
      r_val <= i_load_val;
    end else if (i_tick) begin
      if (r_val < i_tgt)      r_val <= r_val + 8'd1;
      else if (r_val > i_tgt) r_val <= r_val - 8'd1;
    end
  end

  // 9-bit difference so 0/255 never alias as "one step away".
  assign w_diff      = {1'b0, r_val} - {1'b0, i_tgt};
  assign o_near      = (w_diff == 9'h000) || (w_diff == 9'h001) || (w_diff == 9'h1FF);
  assign o_at_target = (r_val == i_tgt);
  assign o_val       = r_val;

endmodule

// File: rtl/rgb_color_fader.sv
// Linear RGB fader: accepts target colours, ramps one LSB per prescaled step, drives the PWM word.
module rgb_color_fader
  import rgb_pkg::*;
#(
  parameter int STEP_DIV = 19531,
  parameter int CNT_W    = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:0] target_color,
  input  logic        target_snap,
  input  logic        target_valid,
  output logic        target_ready,
  input  logic        hold,
  output logic [24:0] color_out,
  output logic        busy,
  output logic        done
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(STEP_DIV - 1);

  fade_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  rgb24_t           r_tgt;
  logic             r_done;

  logic [2:0][7:0]  w_cur;
  logic [2:0][7:0]  w_tgt;
  logic [2:0][7:0]  w_load_val;
  logic [2:0]       w_at_tgt;
  logic [2:0]       w_near;
  logic             w_accept;
  logic             w_snap;
  logic             w_tick;
  logic             w_last_step;

  assign w_accept    = target_valid && target_ready;
  assign w_snap      = w_accept && target_snap;
  assign w_tick      = (r_state == FADING) && !hold && (r_cnt == LP_LAST);
  // On a tick every channel moves at most one LSB, so "all within one" means this tick finishes.
  assign w_last_step = &w_near;
  assign w_tgt       = r_tgt;
  assign w_load_val  = target_color;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_ch
      rgb_channel_stepper u_ch (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_load      (w_snap),
        .i_load_val  (w_load_val[gi]),
        .i_tick      (w_tick),
        .i_tgt       (w_tgt[gi]),
        .o_val       (w_cur[gi]),
        .o_at_target (w_at_tgt[gi]),
        .o_near      (w_near[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_tgt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_tgt <= target_color;
            if (target_snap || (target_color == w_cur)) begin
              r_done <= 1'b1;
            end else begin
              r_state <= FADING;
              r_cnt   <= '0;
            end
          end
        end
        FADING: begin
          if (!hold) begin
            if (r_cnt == LP_LAST) begin
              r_cnt <= '0;
              if (w_last_step) begin
                r_state <= IDLE;
                r_done  <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign target_ready = (r_state == IDLE);
  assign busy         = (r_state == FADING);
  assign done         = r_done;
  assign color_out    = pack_color(rgb24_t'(w_cur));

endmodule

// File: tb/tb_rgb_color_fader.sv
// Directed bench for rgb_color_fader with STEP_DIV = 4.
module tb_rgb_color_fader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [23:0] target_color;
  logic        target_snap;
  logic        target_valid;
  logic        target_ready;
  logic        hold;
  logic [24:0] color_out;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  rgb_color_fader #(.STEP_DIV(4), .CNT_W(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .target_color (target_color),
    .target_snap  (target_snap),
    .target_valid (target_valid),
    .target_ready (target_ready),
    .hold         (hold),
    .color_out    (color_out),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int done_cnt, busy_cnt, rdy_cnt;
    reset_n      = 1'b0;
    target_color = '0;
    target_snap  = 1'b0;
    target_valid = 1'b0;
    hold         = 1'b0;
    #23;
    check("rst_color", 32'(color_out), 32'h0);
    check("rst_busy",  32'(busy), 32'h0);
    check("rst_done",  32'(done), 32'h0);
    reset_n = 1'b1;
    #1;
    check("rst_ready", 32'(target_ready), 32'h1);
    edges(1);

    // Fade to the current colour completes immediately.
    target_valid = 1'b1;
    edges(1);
    target_valid = 1'b0;
    check("eq_done",  32'(done), 32'h1);
    check("eq_busy",  32'(busy), 32'h0);
    check("eq_color", 32'(color_out), 32'h0);
    edges(1);
    check("eq_done_clr", 32'(done), 32'h0);

    // 000000 -> FF0080
    target_color = 24'hFF0080;
    target_valid = 1'b1;
    edges(1);
    target_valid = 1'b0;
    check("up_busy0",  32'(busy), 32'h1);
    check("up_ready0", 32'(target_ready), 32'h0);
    done_cnt = 0;
    for (int e = 1; e <= 1021; e++) begin
      edges(1);
      if (done) done_cnt++;
      if (e == 511)  check("up_e511",  32'(color_out), 32'h0FE007F);
      if (e == 512)  check("up_e512",  32'(color_out), 32'h1000080);
      if (e == 600)  check("up_e600",  32'(color_out), 32'h12C0080);
      if (e == 1019) check("up_e1019", 32'({busy, done, color_out}), {7'd0, 1'b1, 1'b0, 25'h1FC0080});
      if (e == 1020) check("up_e1020", 32'({busy, done, target_ready, color_out}), {6'd0, 1'b0, 1'b1, 1'b1, 25'h1FE0080});
    end
    check("up_done_pulses", 32'(done_cnt), 32'd1);

    // FF0080 -> 000000
    target_color = 24'h000000;
    target_valid = 1'b1;
    edges(1);
    target_valid = 1'b0;
    busy_cnt = (busy) ? 1 : 0;
    for (int e = 1; e <= 1025; e++) begin
      edges(1);
      if (busy) busy_cnt++;
      if (e == 600)  check("dn_e600",  32'(color_out), 32'h0D20000);
      if (e == 1019) check("dn_e1019", 32'(color_out), 32'h0020000);
      if (e == 1020) check("dn_e1020", 32'({done, color_out}), {6'd0, 1'b1, 25'h0});
    end
    check("dn_busy_len", 32'(busy_cnt), 32'd1020);

    // Snap with hold asserted: hold must not block it.
    target_color = 24'h123456;
    target_snap  = 1'b1;
    target_valid = 1'b1;
    hold         = 1'b1;
    edges(1);
    target_valid = 1'b0;
    target_snap  = 1'b0;
    hold         = 1'b0;
    check("snap_color", 32'(color_out), 32'h0243456);
    check("snap_done",  32'(done), 32'h1);
    check("snap_busy",  32'(busy), 32'h0);
    edges(1);
    check("snap_done_clr", 32'(done), 32'h0);

    // Fade 123456 -> 12345A with a second request stalled behind it and 100 hold cycles.
    target_color = 24'h12345A;
    target_valid = 1'b1;
    edges(1);
    target_color = 24'h12345C;
    rdy_cnt = 0;
    for (int e = 1; e <= 116; e++) begin
      edges(1);
      if (e == 5)   hold = 1'b1;
      if (e == 105) hold = 1'b0;
      if (e < 116 && target_ready) rdy_cnt++;
      if (e == 115) check("hold_e115", 32'({done, color_out}), {6'd0, 1'b0, 25'h0243459});
      if (e == 116) check("hold_e116", 32'({done, target_ready, color_out}), {5'd0, 1'b1, 1'b1, 25'h024345A});
    end
    check("stall_ready_low", 32'(rdy_cnt), 32'd0);
    edges(1);
    target_valid = 1'b0;
    check("stall_accept", 32'({busy, done}), 32'h2);
    edges(8);
    check("stall_fade_done", 32'({done, color_out}), {6'd0, 1'b1, 25'h024345C});

    // Asynchronous reset in the middle of a fade.
    target_color = 24'h000000;
    target_valid = 1'b1;
    edges(1);
    target_valid = 1'b0;
    edges(50);
    check("mid_busy", 32'(busy), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_color", 32'(color_out), 32'h0);
    check("arst_busy",  32'(busy), 32'h0);
    check("arst_ready", 32'(target_ready), 32'h1);
    check("arst_done",  32'(done), 32'h0);
    edges(2);
    reset_n = 1'b1;
    edges(2);
    check("post_rst", 32'({busy, done, color_out}), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
